// File: rtl/utopia_rx_sched_if.sv
// Bundle of request, grant and transfer-status signals between the Utopia receive
// ports, the forwarding engine, the CPU and the cell scheduler.
interface utopia_rx_sched_if #(
  parameter int unsigned NumRx     = 4,
  parameter int unsigned CellBytes = 53
);
  logic [NumRx-1:0]             req;
  logic [NumRx-1:0]             port_en;
  logic                         fwd_ready;
  logic                         err_clr;
  logic [NumRx-1:0]             grant;
  logic [$clog2(NumRx)-1:0]     grant_id;
  logic                         xfer_valid;
  logic [$clog2(CellBytes)-1:0] byte_cnt;
  logic                         cell_done;
  logic                         cell_abort;
  logic                         stall_err;
  logic                         busy;

  // Scheduler side.
  modport master (
    input  req, port_en, fwd_ready, err_clr,
    output grant, grant_id, xfer_valid, byte_cnt,
           cell_done, cell_abort, stall_err, busy
  );

  // Receive ports, forwarding engine and CPU side.
  modport slave (
    output req, port_en, fwd_ready, err_clr,
    input  grant, grant_id, xfer_valid, byte_cnt,
           cell_done, cell_abort, stall_err, busy
  );
endinterface

// File: rtl/utopia_rx_sched.sv
// Round-robin cell scheduler: grants one Utopia receive port at a time and sequences
// a full cell of byte beats into the forwarding engine, aborting on a long stall.
module utopia_rx_sched #(
  parameter int unsigned NumRx      = 4,
  parameter int unsigned CellBytes  = 53,
  parameter int unsigned StallLimit = 64
) (
  input  logic              clk,
  input  logic              rst,
  utopia_rx_sched_if.master bus
);
  localparam int unsigned IdW  = $clog2(NumRx);
  localparam int unsigned IW1  = IdW + 1;
  localparam int unsigned CntW = $clog2(CellBytes);
  localparam int unsigned StW  = $clog2(StallLimit + 1);

  localparam logic [CntW-1:0] LastByte  = CntW'(CellBytes - 1);
  localparam logic [StW-1:0]  LastStall = StW'(StallLimit - 1);
  localparam logic [IdW-1:0]  LastPort  = IdW'(NumRx - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IdW-1:0]    ptr_q,   ptr_d;
  logic [NumRx-1:0]  grant_q, grant_d;
  logic [IdW-1:0]    gid_q,   gid_d;
  logic [CntW-1:0]   cnt_q,   cnt_d;
  logic [StW-1:0]    stall_q, stall_d;
  logic              done_q,  done_d;
  logic              abort_q, abort_d;
  logic              err_q,   err_d;

  logic [NumRx-1:0]  elig;
  logic              found;
  logic [IdW-1:0]    sel;
  logic [IW1-1:0]    idx;

  // Round-robin search starting at the pointer, wrapping modulo NumRx.
  always_comb begin
    elig  = bus.req & bus.port_en;
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int unsigned i = 0; i < NumRx; i++) begin
      idx = {1'b0, ptr_q} + IW1'(i);
      if (idx >= IW1'(NumRx)) begin
        idx = idx - IW1'(NumRx);
      end
      if (!found && elig[idx[IdW-1:0]]) begin
        found = 1'b1;
        sel   = idx[IdW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    gid_d   = gid_q;
    cnt_d   = cnt_q;
    stall_d = stall_q;
    done_d  = 1'b0;
    abort_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d      = '0;
          grant_d[sel] = 1'b1;
          gid_d        = sel;
          cnt_d        = '0;
          stall_d      = '0;
          state_d      = XFER;
        end
      end

      XFER: begin
        if (bus.fwd_ready) begin
          stall_d = '0;
          if (cnt_q == LastByte) begin
            done_d  = 1'b1;
            grant_d = '0;
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (stall_q == LastStall) begin
          abort_d = 1'b1;
          grant_d = '0;
          cnt_d   = '0;
          stall_d = '0;
          state_d = DONE;
        end else begin
          stall_d = stall_q + 1'b1;
        end
      end

      DONE: begin
        ptr_d   = (gid_q == LastPort) ? '0 : gid_q + 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // A new abort outranks a simultaneous CPU clear.
    err_d = err_q;
    if (bus.err_clr) begin
      err_d = 1'b0;
    end
    if (abort_d) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      gid_q   <= '0;
      cnt_q   <= '0;
      stall_q <= '0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      gid_q   <= gid_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      done_q  <= done_d;
      abort_q <= abort_d;
      err_q   <= err_d;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.grant_id   = gid_q;
  assign bus.byte_cnt   = cnt_q;
  assign bus.xfer_valid = (state_q == XFER) && bus.fwd_ready;
  assign bus.cell_done  = done_q;
  assign bus.cell_abort = abort_q;
  assign bus.stall_err  = err_q;
  assign bus.busy       = (state_q != IDLE);

  a_grant_onehot : assert property (@(posedge clk) disable iff (!rst) $onehot0(grant_q));
  a_one_pulse    : assert property (@(posedge clk) disable iff (!rst) !(done_q && abort_q));
endmodule

// File: tb/tb_utopia_rx_sched.sv
// Directed bench for utopia_rx_sched: a cell-level behavioural model checked every
// cycle, plus hand-computed expectations per scenario.
module tb_utopia_rx_sched;
  localparam int unsigned NumRx      = 4;
  localparam int unsigned CellBytes  = 53;
  localparam int unsigned StallLimit = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  utopia_rx_sched_if #(.NumRx(NumRx), .CellBytes(CellBytes)) bus ();

  utopia_rx_sched #(
    .NumRx(NumRx),
    .CellBytes(CellBytes),
    .StallLimit(StallLimit)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vectors    = 0;
  int miscompares = 0;
  bit chk_en     = 1'b0;
  int cyc        = 0;

  function automatic void check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Behavioural model: a cell in flight, a one-cycle tail after it, round-robin by "next port".
  bit m_cell, m_tail, m_done_p, m_abort_p, m_err;
  int m_port, m_beat, m_stall, m_next;
  int mod_g[$];
  int mod_done, mod_abort;

  initial forever begin
    @(posedge clk);
    cyc++;
    if (!rst) begin
      m_cell = 0; m_tail = 0; m_done_p = 0; m_abort_p = 0; m_err = 0;
      m_port = 0; m_beat = 0; m_stall = 0; m_next = 0;
    end else begin
      m_done_p  = 0;
      m_abort_p = 0;
      if (bus.err_clr) m_err = 0;
      if (m_cell) begin
        if (bus.fwd_ready) begin
          m_beat++;
          m_stall = 0;
          if (m_beat == CellBytes) begin
            m_cell = 0; m_tail = 1; m_done_p = 1; mod_done++;
            m_next = (m_port + 1) % NumRx;
          end
        end else begin
          m_stall++;
          if (m_stall == StallLimit) begin
            m_cell = 0; m_tail = 1; m_abort_p = 1; m_err = 1; mod_abort++;
            m_next = (m_port + 1) % NumRx;
          end
        end
      end else if (m_tail) begin
        m_tail = 0;
      end else begin
        for (int k = 0; k < NumRx; k++) begin
          int p;
          p = (m_next + k) % NumRx;
          if (!m_cell && bus.req[p] && bus.port_en[p]) begin
            m_cell = 1; m_port = p; m_beat = 0; m_stall = 0;
            mod_g.push_back(p);
          end
        end
      end
    end
  end

  // Observations of the DUT itself, used by the per-scenario literal checks.
  int dut_g[$];
  int dut_gc[$];
  int dut_dc[$];
  int dut_done, dut_abort, dut_beats, max_cnt;
  logic [NumRx-1:0] prev_grant = '0;

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("grant", int'(bus.grant), m_cell ? (1 << m_port) : 0);
      if (m_cell) begin
        check("grant_id", int'(bus.grant_id), m_port);
        check("byte_cnt", int'(bus.byte_cnt), m_beat);
      end
      check("xfer_valid", int'(bus.xfer_valid), int'(m_cell && bus.fwd_ready));
      check("cell_done", int'(bus.cell_done), int'(m_done_p));
      check("cell_abort", int'(bus.cell_abort), int'(m_abort_p));
      check("stall_err", int'(bus.stall_err), int'(m_err));
      check("busy", int'(bus.busy), int'(m_cell || m_tail));

      if (bus.grant != '0 && prev_grant == '0) begin
        dut_g.push_back(int'(bus.grant_id));
        dut_gc.push_back(cyc);
      end
      prev_grant = bus.grant;
      if (bus.cell_done) begin
        dut_done++;
        dut_dc.push_back(cyc);
      end
      if (bus.cell_abort) dut_abort++;
      if (bus.xfer_valid) begin
        dut_beats++;
        if (int'(bus.byte_cnt) > max_cnt) max_cnt = int'(bus.byte_cnt);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clr_logs();
    dut_g.delete(); dut_gc.delete(); dut_dc.delete(); mod_g.delete();
    dut_done = 0; dut_abort = 0; dut_beats = 0; max_cnt = 0;
    mod_done = 0; mod_abort = 0;
  endtask

  function automatic void check_seq(input string name, input int q[$], input int n, input int e[5]);
    check({name, "_len"}, q.size(), n);
    for (int i = 0; i < n; i++) check($sformatf("%s_%0d", name, i), q[i], e[i]);
  endfunction

  int e[5];

  initial begin
    bus.req = '0; bus.port_en = 4'hF; bus.fwd_ready = 1'b1; bus.err_clr = 1'b0;
    rst = 1'b0;
    tick(2);
    chk_en = 1'b1;
    check("rst_grant", int'(bus.grant), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_byte_cnt", int'(bus.byte_cnt), 0);
    check("rst_stall_err", int'(bus.stall_err), 0);
    rst = 1'b1;

    // Single port, held for two cells then dropped.
    clr_logs();
    bus.req = 4'b0100;
    tick(60);
    bus.req = '0;
    tick(60);
    e = '{2, 2, 0, 0, 0};
    check_seq("t1_dut_grants", dut_g, 2, e);
    check_seq("t1_mod_grants", mod_g, 2, e);
    check("t1_done_cnt", dut_done, 2);
    check("t1_mod_done", mod_done, 2);
    check("t1_done_lat", dut_dc[0] - dut_gc[0], 53);
    check("t1_period", dut_gc[1] - dut_gc[0], 55);
    check("t1_max_byte_cnt", max_cnt, 52);
    check("t1_beats", dut_beats, 106);

    // Fairness from a freshly reset pointer.
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    clr_logs();
    bus.req = 4'hF;
    tick(222);
    e = '{0, 1, 2, 3, 0};
    check_seq("t2_dut_grants", dut_g, 5, e);
    check_seq("t2_mod_grants", mod_g, 5, e);
    check("t2_done_cnt", dut_done, 4);
    for (int i = 0; i < 4; i++) check($sformatf("t2_period_%0d", i), dut_gc[i+1] - dut_gc[i], 55);
    bus.req = '0;
    tick(60);

    // Mask: only ports 1 and 3; port 1 disabled during its second cell.
    clr_logs();
    bus.port_en = 4'b1010;
    bus.req = 4'hF;
    tick(130);
    bus.port_en = 4'b1000;
    tick(60);
    bus.req = '0;
    tick(60);
    e = '{1, 3, 1, 3, 0};
    check_seq("t3_dut_grants", dut_g, 4, e);
    check_seq("t3_mod_grants", mod_g, 4, e);
    check("t3_done_cnt", dut_done, 4);
    check("t3_beats", dut_beats, 4 * 53);

    // Backpressure: fwd_ready alternates 0,1 starting in the first XFER cycle.
    clr_logs();
    bus.port_en = 4'hF;
    bus.req = 4'b0001;
    tick(1);
    for (int i = 0; i < 120; i++) begin
      if (i == 0) bus.req = '0;
      bus.fwd_ready = (i % 2 == 1);
      tick(1);
    end
    bus.fwd_ready = 1'b1;
    check("t4_done_cnt", dut_done, 1);
    check("t4_abort_cnt", dut_abort, 0);
    check("t4_beats", dut_beats, 53);
    check("t4_done_lat", dut_dc[0] - dut_gc[0], 106);
    check("t4_stall_err", int'(bus.stall_err), 0);

    // Stall: 63 stalls survive, then 11 beats, then 64 stalls abort.
    clr_logs();
    bus.req = 4'hF;
    tick(1);
    bus.fwd_ready = 1'b0;
    tick(63);
    check("t5_no_early_abort", dut_abort, 0);
    bus.fwd_ready = 1'b1;
    tick(11);
    check("t5_beat_idx", int'(bus.byte_cnt), 11);
    bus.fwd_ready = 1'b0;
    tick(64);
    check("t5_abort_pulse", int'(bus.cell_abort), 1);
    check("t5_err_set", int'(bus.stall_err), 1);
    bus.fwd_ready = 1'b1;
    tick(3);
    bus.req = '0;
    tick(60);
    e = '{1, 2, 0, 0, 0};
    check_seq("t5_dut_grants", dut_g, 2, e);
    check_seq("t5_mod_grants", mod_g, 2, e);
    check("t5_abort_cnt", dut_abort, 1);
    check("t5_mod_abort", mod_abort, 1);
    check("t5_done_cnt", dut_done, 1);
    check("t5_err_sticky", int'(bus.stall_err), 1);
    bus.err_clr = 1'b1;
    tick(1);
    bus.err_clr = 1'b0;
    check("t5_err_cleared", int'(bus.stall_err), 0);

    // Reset at beat 30 of a port-3 cell, then a port-1-only request.
    clr_logs();
    bus.req = 4'hF;
    tick(1);
    tick(30);
    check("t6_beat_30", int'(bus.byte_cnt), 30);
    check("t6_grant_pre", int'(bus.grant), 8);
    rst = 1'b0;
    tick(1);
    check("t6_grant", int'(bus.grant), 0);
    check("t6_byte_cnt", int'(bus.byte_cnt), 0);
    check("t6_busy", int'(bus.busy), 0);
    check("t6_xfer_valid", int'(bus.xfer_valid), 0);
    check("t6_done", int'(bus.cell_done), 0);
    check("t6_abort", int'(bus.cell_abort), 0);
    rst = 1'b1;
    bus.req = 4'b0010;
    tick(1);
    check("t6_regrant", int'(bus.grant), 2);
    check("t6_regrant_id", int'(bus.grant_id), 1);
    bus.req = '0;
    tick(60);
    check("t6_done_cnt", dut_done, 1);
    check("t6_abort_cnt", dut_abort, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/utopia_rx_sched.md
# utopia_rx_sched

Round-robin cell scheduler that shares the single forwarding datapath of the quad ATM switch among the `NumRx` Utopia receive ports. Each receive port raises a request when it holds a complete cell. The scheduler grants one port at a time and sequences the byte transfer of that cell into the forwarding engine. It is locked for a full cell. The CPU interface supplies a per-port enable mask and observes a sticky stall-timeout error.

## Interface
- `NumRx`, 4: number of receive ports requesting the datapath; legal range 2..16.
- `CellBytes`, 53: bytes per ATM cell, one byte per transfer beat.
- `StallLimit`, 64: consecutive stalled beats within one cell that trigger an abort.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-low reset.
- `req`  in  NumRx: bit i high means port i holds a complete cell.
- `port_en`  in  NumRx: CPU enable mask; a disabled port is never granted.
- `fwd_ready`  in  1: forwarding engine accepts a byte this cycle.
- `err_clr`  in  1: CPU clears `stall_err`.
- `grant`  out  NumRx: one-hot grant to the port being transferred; zero when not transferring.
- `grant_id`  out  $clog2(NumRx): index of the granted port.
- `xfer_valid`  out  1: a byte beat occurs this cycle.
- `byte_cnt`  out  $clog2(CellBytes): index of the current byte within the cell.
- `cell_done`  out  1: one-cycle pulse when a cell completes.
- `cell_abort`  out  1: one-cycle pulse when a cell is aborted on stall.
- `stall_err`  out  1: sticky flag, set on abort.
- `busy`  out  1: high in XFER and DONE.

## Operation
- States: IDLE, XFER, DONE.
- On reset (`rst`=0 at a clock edge), outputs take these values:
  - state=IDLE and rr pointer=0.
  - `grant`=0, `grant_id`=0, `byte_cnt`=0.
  - `cell_done`=0, `cell_abort`=0, `stall_err`=0, `busy`=0.
- IDLE:
  - Compute `elig = req & port_en`.
  - If `elig` is nonzero, select the first set bit searching pointer, pointer+1, … with wrap modulo `NumRx`.
  - Register the selection into `grant`/`grant_id`, clear `byte_cnt` and the stall counter, and go to XFER.
  - Otherwise remain in IDLE.
- XFER:
  - `xfer_valid = (state==XFER) & fwd_ready` (combinational).
  - On each beat, `byte_cnt` increments and the stall counter clears.
  - On a beat with `byte_cnt==CellBytes-1`: go to DONE with the completed flag set.
  - When `fwd_ready`=0: the stall counter increments. When it reaches `StallLimit`, go to DONE with the aborted flag set.
- DONE (one cycle):
  - `grant` is cleared.
  - Exactly one of `cell_done`/`cell_abort` is pulsed, registered so that it is high during the DONE cycle.
  - Pointer becomes (`grant_id`+1) mod `NumRx`.
  - Return to IDLE.
  - On abort, `stall_err` is set.
- `stall_err` clears on `err_clr`=1. If set and clear occur in the same cycle, set wins.
- `busy` is high in XFER and DONE.
- Once a port is granted, changes to `req` or `port_en` are ignored until DONE. Disabling a port mid-cell does not truncate the cell.
- Pointer advances only after a grant, never while idle.
- `byte_cnt` is never compared beyond `CellBytes-1`. Its width is exactly $clog2(CellBytes), 6 bits for 53.

## Timing
- Request seen in IDLE at edge n: `grant` and `busy` high after edge n; the first beat is possible in cycle n+1.
- A cell with `fwd_ready` tied high:
  - 53 XFER cycles, then 1 DONE cycle, then 1 IDLE cycle.
  - Back-to-back cells therefore take 55 cycles per cell; there is no IDLE bypass.
- `cell_done` is asserted the cycle after the final beat.
- The abort occurs after exactly `StallLimit` consecutive `fwd_ready`=0 cycles in XFER. `cell_abort` is high in the following cycle.
- Reset mid-transfer: on the next edge all outputs return to their reset values. No `cell_done` or `cell_abort` pulse is produced.

## Test plan
- **Single port:** reset, `port_en`=4'hF, `req`=4'b0100, `fwd_ready`=1.
  - `grant`=4'b0100 and `grant_id`=2 for 53 cycles.
  - `byte_cnt` runs 0..52.
  - `cell_done` pulses once at cycle 54.
  - Next grant goes to port 2 again if it is still requesting.
- **Fairness:** `req`=4'hF held, `fwd_ready`=1.
  - Grant order is 0,1,2,3,0 with a 55-cycle period.
  - Exactly 4 `cell_done` pulses in 220 cycles.
- **Mask:** `req`=4'hF, `port_en`=4'b1010.
  - Grants alternate 1,3,1,3.
  - Ports 0 and 2 are never granted.
  - Clearing `port_en[1]` mid-cell still completes all 53 beats.
- **Backpressure:** `fwd_ready` toggles 1,0 each cycle.
  - 53 beats complete over 106 cycles.
  - No abort; `stall_err`=0.
- **Stall abort:** `fwd_ready`=0 for 64 cycles after beat 10.
  - `cell_abort` pulses once and `stall_err`=1.
  - Pointer advances past the aborted port.
  - `err_clr` returns `stall_err` to 0.
- **Reset mid-cell:** assert `rst`=0 at beat 30.
  - Next cycle: `grant`=0, `byte_cnt`=0, `busy`=0, no pulses.
  - After release with `req`=4'b0010, the first grant goes to port 1 (pointer is 0).
